// File: rtl/anubis_pi_stage.sv
// anubis_pi_stage: registered forward/inverse Anubis pi column rotation
// Ports: clk, reset_n, in_* write side, out_* read side, level = fill count
module anubis_pi_stage #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [N*N*W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] out_data,
  output logic [1:0]       level
);

  localparam int B = N*N*W;

  logic [B-1:0] fwd;
  logic [B-1:0] inv;
  logic [B-1:0] perm;
  logic [B-1:0] head;
  logic [B-1:0] tail;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int K  = N*r + c;
      localparam int KF = N*((r - c + N) % N) + c;
      localparam int KI = N*((r + c) % N) + c;
      assign fwd[W*K +: W] = in_data[W*KF +: W];
      assign inv[W*K +: W] = in_data[W*KI +: W];
    end
  end

  assign perm      = in_inv ? inv : fwd;
  assign in_ready  = reset_n && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign level     = count;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      unique case (1'b1)
        push && !pop: begin
          if (count == 2'd0) head <= perm;
          else               tail <= perm;
          count <= count + 2'd1;
        end
        pop && !push: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        push && pop: begin
          head <= (count == 2'd1) ? perm : tail;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_anubis_pi_stage.sv
// tb_anubis_pi_stage: table vectors plus scoreboarded traffic
// Covers N=4/W=8, N=2/W=4 and N=5/W=8 instances
module tb_anubis_pi_stage;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         iv, ir, inv, ov, ordy;
  logic [127:0] din, dout;
  logic [1:0]   lvl;

  logic        s_iv, s_ir, s_inv, s_ov, s_ordy;
  logic [15:0] s_din, s_dout;
  logic [1:0]  s_lvl;

  logic         b_iv, b_ir, b_inv, b_ov, b_ordy;
  logic [199:0] b_din, b_dout;
  logic [1:0]   b_lvl;

  anubis_pi_stage #(.N(4), .W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv), .in_ready(ir), .in_inv(inv), .in_data(din),
    .out_valid(ov), .out_ready(ordy), .out_data(dout), .level(lvl)
  );

  anubis_pi_stage #(.N(2), .W(4)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .in_valid(s_iv), .in_ready(s_ir), .in_inv(s_inv), .in_data(s_din),
    .out_valid(s_ov), .out_ready(s_ordy), .out_data(s_dout),
    .level(s_lvl)
  );

  anubis_pi_stage #(.N(5), .W(8)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_iv), .in_ready(b_ir), .in_inv(b_inv), .in_data(b_din),
    .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_dout),
    .level(b_lvl)
  );

  int vecs = 0;
  int errs = 0;

  logic [199:0] q4[$];
  logic [199:0] q2[$];
  logic [199:0] q5[$];

  typedef struct {
    logic [127:0] d;
    logic         inv;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [199:0] act,
                     input logic [199:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [199:0] pi_model(input logic [199:0] a,
      input int n, input int w, input logic iv_m);
    logic [199:0] res = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        int src = iv_m ? (r + c) % n : (r - c + n) % n;
        for (int b = 0; b < w; b++)
          res[w*(n*r+c)+b] = a[w*(n*src+c)+b];
      end
    return res;
  endfunction

  function automatic logic [199:0] rnd();
    logic [223:0] t;
    t = {$urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom};
    return t[199:0];
  endfunction

  task automatic sb_pop(input string nm, input logic [199:0] act,
                        inout logic [199:0] q[$]);
    if (q.size() == 0) begin
      vecs++;
      errs++;
      $display("FAIL %s: got %0h want nothing", nm, act);
    end else begin
      chk(nm, act, q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (ov && ordy) sb_pop("sb4", {72'd0, dout}, q4);
      if (iv && ir) q4.push_back(pi_model({72'd0, din}, 4, 8, inv));
      if (s_ov && s_ordy) sb_pop("sb2", {184'd0, s_dout}, q2);
      if (s_iv && s_ir)
        q2.push_back(pi_model({184'd0, s_din}, 2, 4, s_inv));
      if (b_ov && b_ordy) sb_pop("sb5", b_dout, q5);
      if (b_iv && b_ir) q5.push_back(pi_model(b_din, 5, 8, b_inv));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] hold;

  initial begin
    tbl[0] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0,
               128'h0306090C_0F020508_0B0E0104_070A0D00};
    tbl[1] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1,
               128'h0B06010C_07020D08_030E0904_0F0A0500};
    tbl[2] = '{128'h0306090C_0F020508_0B0E0104_070A0D00, 1'b1,
               128'h0F0E0D0C_0B0A0908_07060504_03020100};
    tbl[3] = '{128'h0B06010C_07020D08_030E0904_0F0A0500, 1'b0,
               128'h0F0E0D0C_0B0A0908_07060504_03020100};

    reset_n = 1'b0;
    iv = 0; inv = 0; din = '0; ordy = 0;
    s_iv = 0; s_inv = 0; s_din = '0; s_ordy = 0;
    b_iv = 0; b_inv = 0; b_din = '0; b_ordy = 0;
    #12;
    chk("rst_ov", ov, 0);
    chk("rst_ir", ir, 0);
    chk("rst_lvl", lvl, 0);
    chk("rst_dout", dout, 0);
    reset_n = 1'b1;
    cyc();
    chk("post_rst_ir", ir, 1);

    ordy = 1;
    for (int i = 0; i < 4; i++) begin
      iv = 1; din = tbl[i].d; inv = tbl[i].inv;
      cyc();
      iv = 0;
      chk("tbl_ov", ov, 1);
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp);
      chk("tbl_lvl1", lvl, 1);
      cyc();
      chk("tbl_lvl0", lvl, 0);
    end

    ordy = 0;
    iv = 1; din = rnd(); inv = 0;
    cyc();
    hold = dout;
    din = rnd(); inv = 1;
    cyc();
    chk("stall_stable", dout, hold);
    din = rnd();
    cyc();
    iv = 0;
    chk("bp_lvl2", lvl, 2);
    chk("bp_ir0", ir, 0);
    chk("bp_stable", dout, hold);
    ordy = 1;
    cyc();
    ordy = 0;
    chk("bp_lvl1", lvl, 1);
    chk("bp_ir1", ir, 1);
    ordy = 1;
    repeat (3) cyc();
    chk("bp_drained", q4.size(), 0);

    for (int i = 0; i < 100; i++) begin
      iv = 1; din = rnd(); inv = 1'($urandom_range(0, 1));
      chk("str_ir", ir, 1);
      chk("str_lvl", lvl, (i == 0) ? 0 : 1);
      chk("str_ov", ov, (i == 0) ? 0 : 1);
      cyc();
    end
    iv = 0;
    repeat (2) cyc();
    chk("str_drained", q4.size(), 0);

    ordy = 0;
    iv = 1; din = rnd();
    repeat (2) cyc();
    iv = 0;
    chk("mid_lvl2", lvl, 2);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    q4.delete(); q2.delete(); q5.delete();
    #1;
    chk("mid_ov", ov, 0);
    chk("mid_ir", ir, 0);
    chk("mid_lvl", lvl, 0);
    chk("mid_dout", dout, 0);
    cyc();
    reset_n = 1'b1;
    ordy = 1;
    iv = 1; din = rnd(); inv = 0;
    cyc();
    iv = 0;
    chk("mid_first", dout, pi_model({72'd0, din}, 4, 8, 1'b0));
    repeat (2) cyc();

    s_ordy = 1;
    s_iv = 1; s_din = 16'h3210; s_inv = 0;
    cyc();
    s_iv = 0;
    chk("n2_fwd", s_dout, 16'h1230);
    cyc();

    for (int i = 0; i < 300; i++) begin
      s_iv = 1'($urandom_range(0, 1));
      s_din = 16'($urandom);
      s_inv = 1'($urandom_range(0, 1));
      s_ordy = 1'($urandom_range(0, 1));
      b_iv = 1'($urandom_range(0, 1));
      b_din = rnd();
      b_inv = 1'($urandom_range(0, 1));
      b_ordy = 1'($urandom_range(0, 1));
      cyc();
    end
    s_iv = 0; b_iv = 0; s_ordy = 1; b_ordy = 1;
    repeat (4) cyc();
    chk("q4_empty", q4.size(), 0);
    chk("q2_empty", q2.size(), 0);
    chk("q5_empty", q5.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
